// File: rtl/int_pkg.sv
// Purpose: shared types and constants for the interrupt handshake path (vectored_int, controller, bench).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_pkg;

  // Number of done sources; vectored_int arbitrates exactly four buffers.
  localparam int unsigned NUM_SRC = 4;

  // Width of a source index (buffer 1..4 encoded as 0..3).
  localparam int unsigned SRC_IDX_W = 2;

  // Upper 30 bits every legal vector address must carry.
  localparam logic [29:0] VEC_HI = 30'h3FFF_FFFF;

  // Source index carried in the low bits of the vector address.
  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  // Handshake controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    ACK     = 3'd2,
    SERVICE = 3'd3,
    COOL    = 3'd4
  } state_e;

  // One-hot mask selecting a single source bit.
  function automatic logic [NUM_SRC-1:0] idx_onehot(input src_idx_t idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/int_pending_reg.sv
// Purpose: sticky per-source pending levels; a set pulse latches a bit, a clear mask releases it.
// Latency: 1 cycle from i_set/i_clr to o_pending.
// Backpressure: none; set has priority over clear on the same bit in the same cycle.
module int_pending_reg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_set,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_pending
);

  logic [W-1:0] r_pending;

  // Clear first, then OR in new sets so a coincident set survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~i_clr) | i_set;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/int_handshake_ctrl.sv
// Purpose: latches buffer done pulses, runs the CPU request/take/return handshake and drives int_ack to vectored_int.
// Latency: done_in pulse to cpu_vec_valid is 4+ACK_WAIT cycles when idle, enabled and taken immediately.
// Backpressure: requests stall while int_enable=0; no nesting while a vector is being serviced.
module int_handshake_ctrl #(
  parameter int unsigned ACK_WAIT = 1,               // 1..7 cycles of int_ack before int_addr is sampled
  parameter logic [29:0] VEC_HI   = int_pkg::VEC_HI
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  done_in,
  input  logic        int_enable,
  input  logic        cpu_int_taken,
  input  logic        cpu_eret,
  input  logic [31:0] int_addr,
  output logic [3:0]  done_out,
  output logic        int_ack,
  output logic        cpu_int_req,
  output logic        cpu_vec_valid,
  output logic [31:0] cpu_vec_pc,
  output logic        err_spurious
);

  import int_pkg::*;

  // Counter value at which int_addr is sampled; the counter starts at 0 on ACK entry.
  localparam logic [2:0] WAIT_LAST = 3'(ACK_WAIT);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2:0]           r_wait_cnt;
  src_idx_t             r_idx;
  logic [NUM_SRC-1:0]   w_pending;
  logic [NUM_SRC-1:0]   w_clr;
  logic                 w_sample_now;
  logic                 w_vec_ok;
  logic                 w_eret_hit;

  logic                 r_int_ack;
  logic                 r_int_req;
  logic                 r_vec_valid;
  logic [31:0]          r_vec_pc;
  logic                 r_err;

  // Sticky pending levels; only the serviced index is ever cleared.
  int_pending_reg #(
    .W (NUM_SRC)
  ) u_pending (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set     (done_in),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  // int_addr is looked at exactly once per ACK visit, after int_ack has been up ACK_WAIT cycles.
  assign w_sample_now = (r_state == ACK) && (r_wait_cnt == WAIT_LAST);

  // A vector is trusted only if it has the fixed upper bits and points at a source that is really pending.
  assign w_vec_ok = (int_addr[31:2] == VEC_HI) && w_pending[int_addr[1:0]];

  // Return-from-interrupt is meaningful only while a vector is being serviced.
  assign w_eret_hit = (r_state == SERVICE) && cpu_eret;
  assign w_clr      = w_eret_hit ? idx_onehot(r_idx) : '0;

  // Next-state decode for the request/take/return handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if ((|w_pending) && int_enable) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // Once the CPU has saved its PC the interrupt must proceed, even if enable drops now.
        if (cpu_int_taken) begin
          w_state_nxt = ACK;
        end else if (!int_enable) begin
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        if (w_sample_now) begin
          w_state_nxt = w_vec_ok ? SERVICE : COOL;
        end
      end
      SERVICE: begin
        if (cpu_eret) begin
          w_state_nxt = COOL;
        end
      end
      COOL: begin
        // One quiet cycle with int_ack low so vectored_int can re-arbitrate cleanly.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, ACK wait counter and serviced index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 3'd0;
      r_idx      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ACK) && !w_sample_now) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end else begin
        r_wait_cnt <= 3'd0;
      end
      if (w_sample_now && w_vec_ok) begin
        r_idx <= int_addr[1:0];
      end
    end
  end

  // Registered handshake outputs, derived from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_req   <= 1'b0;
      r_int_ack   <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec_pc    <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_int_req   <= (w_state_nxt == REQ);
      r_int_ack   <= (w_state_nxt == ACK) || (w_state_nxt == SERVICE);
      r_vec_valid <= w_sample_now && w_vec_ok;
      r_err       <= w_sample_now && !w_vec_ok;
      // The PC is held after service so the CPU can still read it; only a good sample replaces it.
      if (w_sample_now && w_vec_ok) begin
        r_vec_pc <= int_addr;
      end
    end
  end

  assign done_out      = w_pending;
  assign int_ack       = r_int_ack;
  assign cpu_int_req   = r_int_req;
  assign cpu_vec_valid = r_vec_valid;
  assign cpu_vec_pc    = r_vec_pc;
  assign err_spurious  = r_err;

endmodule

// File: tb/tb_int_handshake_ctrl.sv
// Purpose: directed self-checking bench for int_handshake_ctrl with a small vectored_int stand-in.
// Latency: n/a.
// Backpressure: n/a.
module tb_int_handshake_ctrl;

  import int_pkg::*;

  localparam int unsigned ACK_WAIT = 1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  done_in;
  logic        int_enable;
  logic        cpu_int_taken;
  logic        cpu_eret;
  logic [31:0] int_addr;
  logic [3:0]  done_out;
  logic        int_ack;
  logic        cpu_int_req;
  logic        cpu_vec_valid;
  logic [31:0] cpu_vec_pc;
  logic        err_spurious;

  logic        addr_ovr_en;
  logic [31:0] addr_ovr;
  int          pass_cnt;
  int          total_cnt;

  int_handshake_ctrl #(
    .ACK_WAIT (ACK_WAIT),
    .VEC_HI   (30'h3FFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .done_in       (done_in),
    .int_enable    (int_enable),
    .cpu_int_taken (cpu_int_taken),
    .cpu_eret      (cpu_eret),
    .int_addr      (int_addr),
    .done_out      (done_out),
    .int_ack       (int_ack),
    .cpu_int_req   (cpu_int_req),
    .cpu_vec_valid (cpu_vec_valid),
    .cpu_vec_pc    (cpu_vec_pc),
    .err_spurious  (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vectored_int stand-in: highest-numbered pending buffer wins while int_ack is high.
  function automatic logic [1:0] hi_idx(input logic [3:0] p);
    hi_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) hi_idx = 2'(i);
    end
  endfunction

  assign int_addr = addr_ovr_en ? addr_ovr :
                    (int_ack ? {30'h3FFF_FFFF, hi_idx(done_out)} : 32'h0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Bounded wait for cpu_int_req; an expired budget shows up as a failed check.
  task automatic wait_req(input string tag);
    int k = 0;
    while (cpu_int_req !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    check(tag, 32'(cpu_int_req), 32'd1);
  endtask

  // Called in the first REQ cycle: take, wait for the vector, optionally pulse done_in while servicing, then eret.
  task automatic run_txn(input string tag, input logic [31:0] exp_pc, input logic [3:0] svc_done);
    cpu_int_taken = 1'b1;
    tick();
    cpu_int_taken = 1'b0;
    check({tag, "_ack"}, 32'(int_ack), 32'd1);
    check({tag, "_req_drop"}, 32'(cpu_int_req), 32'd0);
    repeat (ACK_WAIT) tick();
    check({tag, "_no_early_vld"}, 32'(cpu_vec_valid), 32'd0);
    tick();
    check({tag, "_vld"}, 32'(cpu_vec_valid), 32'd1);
    check({tag, "_pc"}, cpu_vec_pc, exp_pc);
    done_in = svc_done;
    tick();
    done_in = 4'b0;
    check({tag, "_vld_one"}, 32'(cpu_vec_valid), 32'd0);
    check({tag, "_ack_hold"}, 32'(int_ack), 32'd1);
    check({tag, "_pc_hold"}, cpu_vec_pc, exp_pc);
    check({tag, "_no_nest"}, 32'(cpu_int_req), 32'd0);
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
    check({tag, "_ack_off"}, 32'(int_ack), 32'd0);
    check({tag, "_cool"}, 32'(dut.r_state), 32'(COOL));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_req;
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    done_in       = 4'b0;
    int_enable    = 1'b0;
    cpu_int_taken = 1'b0;
    cpu_eret      = 1'b0;
    addr_ovr_en   = 1'b0;
    addr_ovr      = 32'h0;

    // 1: reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t1_done_out", 32'(done_out), 32'h0);
    check("t1_ack", 32'(int_ack), 32'd0);
    check("t1_req", 32'(cpu_int_req), 32'd0);
    check("t1_vld", 32'(cpu_vec_valid), 32'd0);
    check("t1_pc", cpu_vec_pc, 32'h0);
    check("t1_err", 32'(err_spurious), 32'd0);
    check("t1_state", 32'(dut.r_state), 32'(IDLE));

    // 2: single source, buffer 1
    int_enable = 1'b1;
    done_in    = 4'b0001;
    tick();
    done_in = 4'b0;
    check("t2_pend", 32'(done_out), 32'h1);
    check("t2_req_not_yet", 32'(cpu_int_req), 32'd0);
    wait_req("t2_req");
    run_txn("t2", 32'hFFFF_FFFC, 4'b0000);
    check("t2_cleared", 32'(done_out), 32'h0);
    tick();
    check("t2_idle", 32'(dut.r_state), 32'(IDLE));

    // 3: new pulse during service is held, then requested after COOL
    done_in = 4'b0010;
    tick();
    done_in = 4'b0;
    wait_req("t3a_req");
    run_txn("t3a", 32'hFFFF_FFFD, 4'b0001);
    check("t3_left", 32'(done_out), 32'h1);
    wait_req("t3b_req");
    run_txn("t3b", 32'hFFFF_FFFC, 4'b0000);
    check("t3_cleared", 32'(done_out), 32'h0);

    // 4: two sources in one cycle, buffer 4 first
    done_in = 4'b1001;
    tick();
    done_in = 4'b0;
    check("t4_pend", 32'(done_out), 32'h9);
    wait_req("t4a_req");
    run_txn("t4a", 32'hFFFF_FFFF, 4'b0000);
    check("t4_left", 32'(done_out), 32'h1);
    wait_req("t4b_req");
    run_txn("t4b", 32'hFFFF_FFFC, 4'b0000);
    check("t4_cleared", 32'(done_out), 32'h0);

    // 5: disabled, stray eret, enable then withdraw before taken
    tick();
    int_enable = 1'b0;
    done_in    = 4'b0100;
    tick();
    done_in = 4'b0;
    saw_req = 1'b0;
    repeat (20) begin
      tick();
      if (cpu_int_req !== 1'b0) saw_req = 1'b1;
    end
    check("t5_no_req", 32'(saw_req), 32'd0);
    cpu_eret = 1'b1;
    tick();
    cpu_eret = 1'b0;
    check("t5_eret_ignored", 32'(done_out), 32'h4);
    int_enable = 1'b1;
    tick();
    check("t5_req", 32'(cpu_int_req), 32'd1);
    int_enable = 1'b0;
    tick();
    check("t5_req_drop", 32'(cpu_int_req), 32'd0);
    check("t5_idle", 32'(dut.r_state), 32'(IDLE));
    check("t5_pend_kept", 32'(done_out), 32'h4);

    // 6: taken beats enable drop, then a bad vector, then reset during service
    int_enable = 1'b1;
    wait_req("t6_req");
    cpu_int_taken = 1'b1;
    int_enable    = 1'b0;
    tick();
    cpu_int_taken = 1'b0;
    int_enable    = 1'b1;
    check("t6_taken_wins", 32'(dut.r_state), 32'(ACK));
    addr_ovr_en = 1'b1;
    addr_ovr    = 32'hFFFF_FFF8;
    repeat (ACK_WAIT) tick();
    check("t6_err_early", 32'(err_spurious), 32'd0);
    tick();
    check("t6_err", 32'(err_spurious), 32'd1);
    check("t6_ack_drop", 32'(int_ack), 32'd0);
    check("t6_no_vld", 32'(cpu_vec_valid), 32'd0);
    check("t6_pend_kept", 32'(done_out), 32'h4);
    check("t6_cool", 32'(dut.r_state), 32'(COOL));
    tick();
    addr_ovr_en = 1'b0;
    check("t6_err_once", 32'(err_spurious), 32'd0);
    wait_req("t6_rereq");
    cpu_int_taken = 1'b1;
    tick();
    cpu_int_taken = 1'b0;
    repeat (ACK_WAIT + 1) tick();
    check("t6_vld", 32'(cpu_vec_valid), 32'd1);
    check("t6_pc", cpu_vec_pc, 32'hFFFF_FFFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack", 32'(int_ack), 32'd0);
    check("t6_rst_vld", 32'(cpu_vec_valid), 32'd0);
    check("t6_rst_pc", cpu_vec_pc, 32'h0);
    check("t6_rst_done", 32'(done_out), 32'h0);
    check("t6_rst_req", 32'(cpu_int_req), 32'd0);
    check("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/int_handshake_ctrl.md
Name: int_handshake_ctrl

Overview:
- Downstream consumer of vectored_int and bridge to the CPU.
- Latches per-buffer done pulses into sticky levels that drive vectored_int's done1..done4.
- Runs the interrupt request/take/return handshake with the CPU and drives int_ack into vectored_int.
- Captures int_addr as the vector PC, then clears the serviced source on return-from-interrupt.

Parameters:
- NUM_SRC, 4: number of done sources. Fixed at 4 to match vectored_int.
- ACK_WAIT, 1: cycles int_ack is held before int_addr is sampled. Range 1..7.
- VEC_HI, 30'h3FFFFFFF: required upper 30 bits of a valid int_addr.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- done_in  in  4  one-cycle done pulses from buffers 1..4 (bit0 = buffer 1)
- int_enable  in  1  global interrupt enable from the CPU status register
- cpu_int_taken  in  1  CPU has reached a safe point and saved its PC
- cpu_eret  in  1  one-cycle return-from-interrupt pulse
- int_addr  in  32  vector from vectored_int
- done_out  out  4  sticky pending levels to vectored_int done1..done4
- int_ack  out  1  acknowledge to vectored_int
- cpu_int_req  out  1  interrupt request to the CPU
- cpu_vec_valid  out  1  one-cycle strobe: cpu_vec_pc is valid
- cpu_vec_pc  out  32  captured vector address
- err_spurious  out  1  one-cycle strobe: invalid vector sampled

Behaviour:
- Reset (async, rst_n=0): all outputs 0, pending=4'b0, state=IDLE, wait counter=0, captured index=0. All outputs are registered.
- Pending register:
  - pending[i] sets on done_in[i]; it clears only when the serviced index receives cpu_eret.
  - If set and clear hit the same bit in the same cycle, set wins.
  - done_out = pending.
- IDLE: go to REQ when pending != 0 and int_enable=1. cpu_int_req asserts in the first REQ cycle.
- REQ:
  - cpu_int_req=1.
  - cpu_int_taken=1 -> ACK, int_ack=1 from the next cycle. Taken wins over a same-cycle int_enable drop.
  - Otherwise, int_enable=0 -> IDLE and cpu_int_req drops.
- ACK:
  - int_ack=1 and cpu_int_req=0.
  - Count ACK_WAIT cycles, then sample int_addr.
  - Valid sample: int_addr[31:2]==VEC_HI and pending[int_addr[1:0]]==1. Register cpu_vec_pc=int_addr and idx=int_addr[1:0]; go to SERVICE.
  - Invalid sample (including undriven/Z): pulse err_spurious, drop int_ack, go to COOL.
- SERVICE:
  - cpu_vec_valid=1 in the first SERVICE cycle only.
  - int_ack stays 1 and cpu_vec_pc stays stable.
  - New done_in pulses set pending but cause no request (no nesting).
  - cpu_eret -> clear pending[idx], drop int_ack, go to COOL.
- COOL: one cycle, all handshake outputs 0, then IDLE. This gives vectored_int a cycle with int_ack low before re-arbitration.
- Latency: from a done_in pulse (IDLE, enabled, CPU takes immediately) to cpu_vec_valid is 4+ACK_WAIT cycles.
- cpu_eret outside SERVICE is ignored.
- Reset mid-operation: immediate return to the reset state. Pending pulses are lost.

Decomposition:
- Shared package int_pkg:
  - FSM state enum: IDLE, REQ, ACK, SERVICE, COOL.
  - NUM_SRC, VEC_HI and the source-index type. vectored_int and the bench use the same package.
- Sub-module int_pending_reg: 4-bit sticky set/clear register with set-priority and async reset. It is natural to reuse for future sources.

Test Plan:
1. Reset, then no stimulus for 10 cycles -> all outputs 0, state IDLE, done_out=4'b0000.
2. done_in=4'b0001 pulse, int_enable=1, cpu_int_taken asserted one cycle after cpu_int_req -> int_ack=1, cpu_vec_valid pulse with cpu_vec_pc=32'hFFFFFFFC. Then cpu_eret -> done_out=4'b0000, int_ack=0 the next cycle.
3. done_in=4'b0010 pulse, taken, then done_in=4'b0001 pulse during SERVICE -> cpu_vec_pc=32'hFFFFFFFD. After cpu_eret and COOL, a new request is made -> cpu_vec_pc=32'hFFFFFFFC.
4. done_in=4'b1001 in the same cycle -> cpu_vec_pc=32'hFFFFFFFF (buffer 4). After eret, done_out=4'b0001 and a second request follows.
5. int_enable=0 with done_in=4'b0100 pending -> no cpu_int_req for 20 cycles. Then int_enable=1 -> request. Then int_enable=0 before taken -> back to IDLE, with pending still 4'b0100.
6. Force int_addr=32'hFFFFFFF8 (wrong upper bits) during ACK -> err_spurious pulses once, int_ack drops, no cpu_vec_valid, pending unchanged. Also: assert rst_n=0 during SERVICE -> all outputs 0 asynchronously.
